ft_async_writer: RTL and testbench
==================================

# ft_async_writer

Transmit-direction engine for the FT2232H asynchronous 245 FIFO interface. It buffers bytes written by the external (uP) side in a small synchronous FIFO and drains them into the FT2232H transmit FIFO. Each byte is a WR_N strobe paced by TXE_N, with setup, pulse, hold and precharge times counted in `clk` cycles. It shares the FT data bus with the read engine and is the write-side counterpart of that block.

## Interface
- DATA, 8, data width (FT bus width)
- ADDR, 4, log2 of internal FIFO depth (16 entries)
- SETUP_CYC, 1, cycles data is driven before WR_N falls (≥5 ns at 200 MHz)
- PULSE_CYC, 6, cycles WR_N is held low (≥30 ns)
- HOLD_CYC, 1, cycles data is held after WR_N rises (≥5 ns)
- PRECHG_CYC, 3, cycles between end of hold and the next launch decision (≥14 ns); legal range ≥3

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock (200 MHz nominal)
- rst_n  in  1  synchronous active-low reset
- ext_wr  in  1  write strobe from the uP side; one byte per cycle high
- ext_wr_data  in  DATA  byte to transmit
- ext_full  out  1  FIFO full; writes are dropped
- ext_level  out  ADDR+1  current FIFO occupancy, 0..2^ADDR
- ext_overflow  out  1  one-cycle pulse when an ext_wr is dropped
- bus_busy  in  1  read engine owns the FT data bus; no new launch while high
- TXE_N  in  1  FT2232H transmit FIFO has space (active low, asynchronous)
- WR_N  out  1  FT2232H write strobe
- ft_wr_data  out  DATA  data driven to the FT bus
- ft_data_oe  out  1  tristate enable for ft_wr_data

## Operation
- TXE_N passes through a 2-FF synchronizer (reset value 1) to produce txe_s.
- FIFO behaviour:
  - First-word-fall-through, depth 2^ADDR.
  - A write occurs on ext_wr && !ext_full.
  - ext_wr && ext_full drops the byte and pulses ext_overflow the next cycle. This applies even if a pop happens the same cycle.
  - A simultaneous push and pop when not full leaves ext_level unchanged.
  - Pointers wrap modulo 2^ADDR. ext_level is registered.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. A single down-counter is loaded on each transition.
  - IDLE: launches when FIFO non-empty && txe_s==0 && !bus_busy. On launch: ft_wr_data <= FIFO head, pop, ft_data_oe <= 1, go to SETUP. Otherwise stay in IDLE with WR_N=1 and ft_data_oe=0.
  - SETUP: SETUP_CYC cycles. At exit WR_N <= 0, go to STROBE.
  - STROBE: PULSE_CYC cycles with WR_N low and data stable. At exit WR_N <= 1, go to HOLD.
  - HOLD: HOLD_CYC cycles with data still driven. At exit ft_data_oe <= 0, go to RECOVER.
  - RECOVER: PRECHG_CYC cycles, then IDLE. This covers the FT raising TXE_N after the write plus synchronizer latency.
- bus_busy and TXE_N are evaluated only in IDLE. Once launched, a byte always completes.
- ft_wr_data holds its last value when ft_data_oe=0.
- Reset values: WR_N=1, ft_data_oe=0, ft_wr_data=0, ext_full=0, ext_level=0, ext_overflow=0, FIFO empty, state IDLE, txe_s=1.
- Reset mid-operation: all of the above apply at the next edge. A byte in flight is lost, and WR_N rises even if it is in STROBE.

## Timing
- For ext_wr at edge k into an empty FIFO, with txe_s=0 and bus free:
  - Launch at edge k+1.
  - WR_N falls at edge k+1+SETUP_CYC.
  - WR_N rises PULSE_CYC cycles later.
  - ft_data_oe falls HOLD_CYC after that.
- Byte period with TXE_N continuously ready is 1+SETUP_CYC+PULSE_CYC+HOLD_CYC+PRECHG_CYC = 12 cycles (60 ns) at defaults.
- After TXE_N falls, a launch occurs no earlier than 2 cycles later (synchronizer). A TXE_N rise is honoured within 2 cycles for any launch decided afterwards.
- ext_full asserts the cycle after the push that makes ext_level = 2^ADDR. It deasserts the cycle after the next pop.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random inputs → WR_N=1, ft_data_oe=0, ft_wr_data=0x00, ext_level=0, ext_full=0.
- Single byte: TXE_N=0, write 0xA5 at edge k → ft_data_oe=1 from k+1, WR_N low for exactly 6 cycles from k+2, ft_wr_data=0xA5 throughout, oe drops at k+9.
- Back-to-back: write 0x01,0x02,0x03 on consecutive cycles with TXE_N=0 → three WR_N pulses, falling edges 12 cycles apart, data in order, ext_level returns to 0.
- Backpressure/full: TXE_N=1, write 17 bytes → ext_level=16, ext_full=1, one ext_overflow pulse on the 17th. Release TXE_N → 16 bytes emitted in order, 17th absent.
- Bus arbitration: bus_busy=1 with FIFO non-empty → no launch. Deassert bus_busy → launch next cycle. Assert bus_busy mid-STROBE → byte completes unchanged.
- Reset mid-strobe: assert rst_n=0 in the 3rd STROBE cycle → WR_N=1 and ft_data_oe=0 at the next edge, FIFO empty, no further strobes.

Source files
------------

// File: rtl/ft_async_writer_if.sv
`default_nettype none
// ============================================================================
// ft_async_writer_if : uP-side write port and FT2232H transmit-side signals
// Rev 1.0
// ============================================================================
interface ft_async_writer_if #(
  parameter int DATA = 8,
  parameter int ADDR = 4
);
  logic            ext_wr;
  logic [DATA-1:0] ext_wr_data;
  logic            ext_full;
  logic [ADDR:0]   ext_level;
  logic            ext_overflow;
  logic            bus_busy;
  logic            TXE_N;
  logic            WR_N;
  logic [DATA-1:0] ft_wr_data;
  logic            ft_data_oe;

  modport master (
    output ext_wr, ext_wr_data, bus_busy, TXE_N,
    input  ext_full, ext_level, ext_overflow, WR_N, ft_wr_data, ft_data_oe
  );

  modport slave (
    input  ext_wr, ext_wr_data, bus_busy, TXE_N,
    output ext_full, ext_level, ext_overflow, WR_N, ft_wr_data, ft_data_oe
  );
endinterface
`default_nettype wire

// File: rtl/ft_async_writer.sv
`default_nettype none
// ============================================================================
// ft_async_writer : FIFO-buffered transmit engine for the FT2232H async 245 bus
// Rev 1.0
// ============================================================================
module ft_async_writer #(
  parameter int DATA       = 8,
  parameter int ADDR       = 4,
  parameter int SETUP_CYC  = 1,
  parameter int PULSE_CYC  = 6,
  parameter int HOLD_CYC   = 1,
  parameter int PRECHG_CYC = 3
) (
  input wire               clk,
  input wire               rst_n,
  ft_async_writer_if.slave ifc
);
  localparam int            c_DEPTH    = 1 << ADDR;
  localparam int            c_CW       = 8;
  localparam logic [ADDR:0] c_FULL_LVL = (ADDR+1)'(c_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  logic [DATA-1:0] r_mem [c_DEPTH];
  logic [ADDR-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR:0]   r_level;
  logic            r_overflow;
  logic            r_txe_meta, r_txe_s;
  state_t          r_state, w_state_nx;
  logic [c_CW-1:0] r_cnt, w_cnt_nx;
  logic            r_wr_n, w_wr_n_nx;
  logic            r_oe, w_oe_nx;
  logic [DATA-1:0] r_data, w_data_nx;
  logic            w_full, w_push, w_pop, w_launch;

  assign w_full   = (r_level == c_FULL_LVL);
  assign w_push   = ifc.ext_wr && !w_full;
  assign w_launch = (r_level != '0) && !r_txe_s && !ifc.bus_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_txe_meta <= 1'b1;
      r_txe_s    <= 1'b1;
    end else begin
      r_txe_meta <= ifc.TXE_N;
      r_txe_s    <= r_txe_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wr_ptr] <= ifc.ext_wr_data;
  end

  // Overflow is judged on the pre-edge full flag, so a same-cycle pop does not rescue the byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= ifc.ext_wr && w_full;
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (ADDR+1)'(1);
        2'b01:   r_level <= r_level - (ADDR+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_wr_n_nx  = r_wr_n;
    w_oe_nx    = r_oe;
    w_data_nx  = r_data;
    w_pop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          w_pop      = 1'b1;
          w_data_nx  = r_mem[r_rd_ptr];
          w_oe_nx    = 1'b1;
          w_state_nx = ST_SETUP;
          w_cnt_nx   = c_CW'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_wr_n_nx  = 1'b0;
          w_state_nx = ST_STROBE;
          w_cnt_nx   = c_CW'(PULSE_CYC - 1);
        end else begin
          w_cnt_nx = r_cnt - c_CW'(1);
        end
      end
      ST_STROBE: begin
        if (r_cnt == '0) begin
          w_wr_n_nx  = 1'b1;
          w_state_nx = ST_HOLD;
          w_cnt_nx   = c_CW'(HOLD_CYC - 1);
        end else begin
          w_cnt_nx = r_cnt - c_CW'(1);
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_oe_nx    = 1'b0;
          w_state_nx = ST_RECOVER;
          w_cnt_nx   = c_CW'(PRECHG_CYC - 1);
        end else begin
          w_cnt_nx = r_cnt - c_CW'(1);
        end
      end
      ST_RECOVER: begin
        if (r_cnt == '0) w_state_nx = ST_IDLE;
        else             w_cnt_nx   = r_cnt - c_CW'(1);
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_wr_n_nx  = 1'b1;
        w_oe_nx    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_wr_n  <= 1'b1;
      r_oe    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_wr_n  <= w_wr_n_nx;
      r_oe    <= w_oe_nx;
      r_data  <= w_data_nx;
    end
  end

  assign ifc.ext_full     = w_full;
  assign ifc.ext_level    = r_level;
  assign ifc.ext_overflow = r_overflow;
  assign ifc.WR_N         = r_wr_n;
  assign ifc.ft_wr_data   = r_data;
  assign ifc.ft_data_oe   = r_oe;
endmodule
`default_nettype wire

// File: tb/tb_ft_async_writer.sv
`default_nettype none
// ============================================================================
// tb_ft_async_writer : scoreboard bench for the FT2232H async write engine
// Rev 1.0
// ============================================================================
module tb_ft_async_writer;
  localparam int c_SETUP  = 1;
  localparam int c_PULSE  = 6;
  localparam int c_HOLD   = 1;
  localparam int c_PRECHG = 3;
  localparam int c_PERIOD = 1 + c_SETUP + c_PULSE + c_HOLD + c_PRECHG;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_data[$];
  int         obs_cyc[$];
  logic       prev_wr_n = 1'b1;

  ft_async_writer_if #(.DATA(8), .ADDR(4)) bus_if ();

  ft_async_writer #(
    .DATA(8), .ADDR(4), .SETUP_CYC(c_SETUP), .PULSE_CYC(c_PULSE),
    .HOLD_CYC(c_HOLD), .PRECHG_CYC(c_PRECHG)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ifc  (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every WR_N falling edge is an emitted byte: log its data and cycle.
  always @(negedge clk) begin
    if (prev_wr_n && !bus_if.WR_N) begin
      obs_data.push_back(bus_if.ft_wr_data);
      obs_cyc.push_back(cyc);
    end
    prev_wr_n <= bus_if.WR_N;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_if.ext_wr      = 1'($urandom_range(0, 1));
      bus_if.ext_wr_data = 8'($urandom);
      bus_if.bus_busy    = 1'($urandom_range(0, 1));
      bus_if.TXE_N       = 1'($urandom_range(0, 1));
      step();
    end
    n_checks++; if (bus_if.WR_N !== 1'b1) $display("FAIL reset_wr_n got=%b exp=1", bus_if.WR_N); else n_pass++;
    n_checks++; if (bus_if.ft_data_oe !== 1'b0) $display("FAIL reset_oe got=%b exp=0", bus_if.ft_data_oe); else n_pass++;
    n_checks++; if (bus_if.ft_wr_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", bus_if.ft_wr_data); else n_pass++;
    n_checks++; if (bus_if.ext_level !== 5'd0) $display("FAIL reset_level got=%0d exp=0", bus_if.ext_level); else n_pass++;
    n_checks++; if (bus_if.ext_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", bus_if.ext_full); else n_pass++;
    n_checks++; if (bus_if.ext_overflow !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", bus_if.ext_overflow); else n_pass++;
    bus_if.ext_wr   = 1'b0;
    bus_if.bus_busy = 1'b0;
    bus_if.TXE_N    = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    obs_data.delete();
    obs_cyc.delete();
  endtask

  task automatic test_single();
    logic exp_wr_n, exp_oe;
    int   bad_data = 0;
    bus_if.ext_wr      = 1'b1;
    bus_if.ext_wr_data = 8'hA5;
    exp_q.push_back(8'hA5);
    step();
    bus_if.ext_wr = 1'b0;
    n_checks++; if (bus_if.ext_level !== 5'd1) $display("FAIL single_level got=%0d exp=1", bus_if.ext_level); else n_pass++;
    n_checks++; if (bus_if.ft_data_oe !== 1'b0) $display("FAIL single_oe_k got=%b exp=0", bus_if.ft_data_oe); else n_pass++;
    for (int j = 1; j <= c_PERIOD; j++) begin
      step();
      exp_wr_n = (j >= 1 + c_SETUP && j < 1 + c_SETUP + c_PULSE) ? 1'b0 : 1'b1;
      exp_oe   = (j < 1 + c_SETUP + c_PULSE + c_HOLD) ? 1'b1 : 1'b0;
      n_checks++;
      if (bus_if.WR_N !== exp_wr_n) $display("FAIL single_wr_n k+%0d got=%b exp=%b", j, bus_if.WR_N, exp_wr_n);
      else n_pass++;
      n_checks++;
      if (bus_if.ft_data_oe !== exp_oe) $display("FAIL single_oe k+%0d got=%b exp=%b", j, bus_if.ft_data_oe, exp_oe);
      else n_pass++;
      if (exp_oe && bus_if.ft_wr_data !== 8'hA5) bad_data++;
    end
    n_checks++; if (bad_data != 0) $display("FAIL single_data_stable got=%0d bad cycles exp=0", bad_data); else n_pass++;
    n_checks++;
    if (obs_data.size() != 1) $display("FAIL single_count got=%0d exp=1", obs_data.size());
    else begin
      logic [7:0] e, d;
      e = exp_q.pop_front();
      d = obs_data.pop_front();
      void'(obs_cyc.pop_front());
      if (d !== e) $display("FAIL single_byte got=%h exp=%h", d, e); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int prev_c = 0;
    for (int i = 0; i < 3; i++) begin
      bus_if.ext_wr      = 1'b1;
      bus_if.ext_wr_data = 8'(i + 1);
      exp_q.push_back(8'(i + 1));
      step();
    end
    bus_if.ext_wr = 1'b0;
    for (int t = 0; t < 80 && obs_data.size() < 3; t++) step();
    n_checks++;
    if (obs_data.size() != 3) $display("FAIL b2b_count got=%0d exp=3", obs_data.size());
    else n_pass++;
    for (int i = 0; i < 3 && obs_data.size() > 0; i++) begin
      logic [7:0] e, d;
      int c;
      e = exp_q.pop_front();
      d = obs_data.pop_front();
      c = obs_cyc.pop_front();
      n_checks++; if (d !== e) $display("FAIL b2b_byte%0d got=%h exp=%h", i, d, e); else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (c - prev_c != c_PERIOD) $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, c - prev_c, c_PERIOD);
        else n_pass++;
      end
      prev_c = c;
    end
    for (int i = 0; i < 14; i++) step();
    n_checks++; if (bus_if.ext_level !== 5'd0) $display("FAIL b2b_level got=%0d exp=0", bus_if.ext_level); else n_pass++;
  endtask

  task automatic test_full();
    int ovf_early = 0;
    bus_if.TXE_N = 1'b1;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 17; i++) begin
      bus_if.ext_wr      = 1'b1;
      bus_if.ext_wr_data = 8'(8'h10 + i);
      if (i < 16) exp_q.push_back(8'(8'h10 + i));
      step();
      if (i < 16 && bus_if.ext_overflow) ovf_early++;
      if (i == 15) begin
        n_checks++; if (bus_if.ext_full !== 1'b1) $display("FAIL full_flag got=%b exp=1", bus_if.ext_full); else n_pass++;
      end
    end
    bus_if.ext_wr = 1'b0;
    n_checks++; if (bus_if.ext_overflow !== 1'b1) $display("FAIL full_ovf_pulse got=%b exp=1", bus_if.ext_overflow); else n_pass++;
    n_checks++; if (bus_if.ext_level !== 5'd16) $display("FAIL full_level got=%0d exp=16", bus_if.ext_level); else n_pass++;
    n_checks++; if (ovf_early != 0) $display("FAIL full_ovf_early got=%0d exp=0", ovf_early); else n_pass++;
    step();
    n_checks++; if (bus_if.ext_overflow !== 1'b0) $display("FAIL full_ovf_width got=%b exp=0", bus_if.ext_overflow); else n_pass++;
    n_checks++; if (obs_data.size() != 0) $display("FAIL full_no_strobe got=%0d exp=0", obs_data.size()); else n_pass++;
    bus_if.TXE_N = 1'b0;
    for (int t = 0; t < 16 * c_PERIOD + 30 && obs_data.size() < 16; t++) step();
    n_checks++; if (obs_data.size() != 16) $display("FAIL full_drain_count got=%0d exp=16", obs_data.size()); else n_pass++;
    for (int i = 0; i < 16 && obs_data.size() > 0; i++) begin
      logic [7:0] e, d;
      e = exp_q.pop_front();
      d = obs_data.pop_front();
      void'(obs_cyc.pop_front());
      n_checks++; if (d !== e) $display("FAIL full_byte%0d got=%h exp=%h", i, d, e); else n_pass++;
    end
    for (int i = 0; i < 30; i++) step();
    n_checks++; if (obs_data.size() != 0) $display("FAIL full_extra_byte got=%0d exp=0", obs_data.size()); else n_pass++;
    n_checks++; if (bus_if.ext_full !== 1'b0) $display("FAIL full_clear got=%b exp=0", bus_if.ext_full); else n_pass++;
  endtask

  task automatic test_bus_arb();
    int low = 0;
    int bad_data = 0;
    bus_if.bus_busy    = 1'b1;
    bus_if.ext_wr      = 1'b1;
    bus_if.ext_wr_data = 8'h5A;
    exp_q.push_back(8'h5A);
    step();
    bus_if.ext_wr = 1'b0;
    for (int i = 0; i < 10; i++) step();
    n_checks++; if (bus_if.ft_data_oe !== 1'b0) $display("FAIL arb_blocked_oe got=%b exp=0", bus_if.ft_data_oe); else n_pass++;
    n_checks++; if (bus_if.ext_level !== 5'd1) $display("FAIL arb_blocked_level got=%0d exp=1", bus_if.ext_level); else n_pass++;
    bus_if.bus_busy = 1'b0;
    step();
    n_checks++; if (bus_if.ft_data_oe !== 1'b1) $display("FAIL arb_launch got=%b exp=1", bus_if.ft_data_oe); else n_pass++;
    for (int j = 1; j <= c_PERIOD; j++) begin
      if (j == 3) bus_if.bus_busy = 1'b1;
      step();
      if (!bus_if.WR_N) low++;
      if (bus_if.ft_data_oe && bus_if.ft_wr_data !== 8'h5A) bad_data++;
    end
    bus_if.bus_busy = 1'b0;
    n_checks++; if (low != c_PULSE) $display("FAIL arb_pulse_len got=%0d exp=%0d", low, c_PULSE); else n_pass++;
    n_checks++; if (bad_data != 0) $display("FAIL arb_data_stable got=%0d exp=0", bad_data); else n_pass++;
    n_checks++;
    if (obs_data.size() != 1) $display("FAIL arb_count got=%0d exp=1", obs_data.size());
    else begin
      logic [7:0] e, d;
      e = exp_q.pop_front();
      d = obs_data.pop_front();
      void'(obs_cyc.pop_front());
      if (d !== e) $display("FAIL arb_byte got=%h exp=%h", d, e); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bus_if.ext_wr      = 1'b1;
    bus_if.ext_wr_data = 8'hC3;
    step();
    bus_if.ext_wr_data = 8'h3C;
    step();
    bus_if.ext_wr = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_checks++; if (bus_if.WR_N !== 1'b0) $display("FAIL mid_in_strobe got=%b exp=0", bus_if.WR_N); else n_pass++;
    rst_n = 1'b0;
    step();
    n_checks++; if (bus_if.WR_N !== 1'b1) $display("FAIL mid_wr_n got=%b exp=1", bus_if.WR_N); else n_pass++;
    n_checks++; if (bus_if.ft_data_oe !== 1'b0) $display("FAIL mid_oe got=%b exp=0", bus_if.ft_data_oe); else n_pass++;
    n_checks++; if (bus_if.ext_level !== 5'd0) $display("FAIL mid_level got=%0d exp=0", bus_if.ext_level); else n_pass++;
    rst_n = 1'b1;
    obs_data.delete();
    obs_cyc.delete();
    for (int i = 0; i < 30; i++) step();
    n_checks++; if (obs_data.size() != 0) $display("FAIL mid_no_strobe got=%0d exp=0", obs_data.size()); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    bus_if.ext_wr      = 1'b0;
    bus_if.ext_wr_data = 8'h00;
    bus_if.bus_busy    = 1'b0;
    bus_if.TXE_N       = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_bus_arb();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
`default_nettype wire
